muldiv_sequencer: RTL

//  Multicycle sequencer for signed MULT/DIV. Sits between the control unit and the Hi/Lo registers.

---
 rtl/muldiv_sequencer_pkg.sv | 22 ++
 rtl/muldiv_sequencer_datapath.sv | 58 +++++
 rtl/muldiv_sequencer.sv | 80 ++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared state encoding, width default and Hi/Lo select codes.
package muldiv_sequencer_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULT  = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIN   = 3'd3,
        ST_DZERO = 3'd4
    } state_t;

    // Result-select codes the control unit uses when steering Hi/Lo onto the bus.
    typedef enum logic [1:0] {
        HILO_NONE = 2'd0,
        HILO_LO   = 2'd1,
        HILO_HI   = 2'd2,
        HILO_BOTH = 2'd3
    } hilo_sel_t;

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// muldiv_sequencer_datapath: Booth multiplier / restoring divider shift registers with sign fix-up.
//   clk    in  clock
//   init   in  latch operands and clear the accumulator
//   step   in  advance one Booth step or one quotient bit
//   is_div in  operation selected at init (1 = divide)
//   op_a   in  multiplicand / dividend
//   op_b   in  multiplier / divisor
//   res    out {hi, lo} as it will be after the current step (product or {remainder, quotient})
module muldiv_sequencer_datapath #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           init,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic [2*W-1:0] res
);

    logic         div, q1, neg_q, neg_r;
    logic [W:0]   acc, acc_n, ms, sh, sum, dif;
    logic [W-1:0] q, q_n, m, a_mag, b_mag, qq, rr;
    logic         q1_n;

    always_comb begin
        a_mag = op_a[W-1] ? -op_a : op_a;
        b_mag = op_b[W-1] ? -op_b : op_b;
        // Divider works on unsigned magnitudes; Booth needs the multiplicand sign-extended.
        ms    = div ? {1'b0, m} : {m[W-1], m};
        sh    = {acc[W-1:0], q[W-1]};
        dif   = sh - ms;
        sum   = (q[0] == q1) ? acc : (q[0] ? acc - ms : acc + ms);
        acc_n = div ? (dif[W] ? sh : dif) : {sum[W], sum[W:1]};
        q_n   = div ? {q[W-2:0], ~dif[W]} : {sum[0], q[W-1:1]};
        q1_n  = div ? q1 : q[0];
        qq    = neg_q ? -q_n : q_n;
        rr    = neg_r ? -acc_n[W-1:0] : acc_n[W-1:0];
        res   = div ? {rr, qq} : {acc_n[W-1:0], q_n};
    end

    always_ff @(posedge clk) begin
        if (init) begin
            div   <= is_div;
            acc   <= '0;
            q1    <= 1'b0;
            q     <= is_div ? a_mag : op_b;
            m     <= is_div ? b_mag : op_a;
            neg_q <= is_div & (op_a[W-1] ^ op_b[W-1]);
            neg_r <= is_div & op_a[W-1];
        end else if (step) begin
            acc <= acc_n;
            q   <= q_n;
            q1  <= q1_n;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle signed MULT/DIV sequencer feeding the Hi/Lo registers.
//   clk, reset              clock, synchronous active-high reset
//   mult_start, div_start   requests, sampled only in IDLE (mult has priority)
//   op_a, op_b              operands, latched on the accepting edge
//   busy                    high from the cycle after acceptance through done
//   done, hilo_load         one-cycle completion / Hi-Lo load pulses
//   hi_out, lo_out          product high/low, or remainder/quotient
//   div_zero                one-cycle pulse for a divide by zero
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             hilo_load,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    state_t             state, nxt;
    logic [CNT_W-1:0]   cnt;
    logic               last, init, step;
    logic [2*WIDTH-1:0] res;

    assign last = cnt == CNT_W'(WIDTH - 1);
    assign step = (state == ST_MULT) || (state == ST_DIV);
    assign init = (state == ST_IDLE) && ((nxt == ST_MULT) || (nxt == ST_DIV));

    always_comb begin
        nxt = ST_IDLE;
        case (state)
            ST_IDLE:         nxt = mult_start ? ST_MULT :
                                   div_start  ? ((op_b != '0) ? ST_DIV : ST_DZERO) : ST_IDLE;
            ST_MULT, ST_DIV: nxt = last ? ST_FIN : state;
            default:         nxt = ST_IDLE;
        endcase
    end

    muldiv_sequencer_datapath #(.W(WIDTH)) u_dp (
        .clk    (clk),
        .init   (init),
        .step   (step),
        .is_div (!mult_start),
        .op_a   (op_a),
        .op_b   (op_b),
        .res    (res)
    );

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hilo_load <= 1'b0;
            div_zero  <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else begin
            state     <= nxt;
            cnt       <= (nxt != state) ? '0 : (step ? cnt + 1'b1 : cnt);
            busy      <= nxt != ST_IDLE;
            done      <= (nxt == ST_FIN) || (nxt == ST_DZERO);
            hilo_load <= nxt == ST_FIN;
            div_zero  <= nxt == ST_DZERO;
            if (nxt == ST_FIN) {hi_out, lo_out} <= res;
        end
    end

endmodule
